// File: rtl/edge_filter_pkg.sv
// Shared types and constants for the input edge filter and related pin-conditioning blocks.
package edge_filter_pkg;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        RISE = 2'b01,
        FALL = 2'b10,
        BOTH = 2'b11
    } edge_sel_t;

    localparam int SYNC_STAGES = 2;
    // Cycles between the pin edge first sampled and the counter value stamped on the event.
    localparam int TS_LATENCY  = 2;

    function automatic logic edge_selected(input edge_sel_t sel, input logic rise);
        logic [1:0] bits;
        bits = sel;
        return rise ? bits[0] : bits[1];
    endfunction

endpackage

// File: rtl/input_edge_filter_if.sv
// Configuration and event/status bundle between the edge filter and its controller.
interface input_edge_filter_if #(
    parameter int FILTER_WIDTH = 8,
    parameter int GLITCH_WIDTH = 16
);
    logic                    enable;
    logic [FILTER_WIDTH-1:0] cfg_filter_len;
    logic [1:0]              cfg_edge_sel;
    logic                    glitch_clr;
    logic                    filt_out;
    logic                    edge_valid;
    logic                    edge_rise;
    logic [63:0]             edge_ts;
    logic [GLITCH_WIDTH-1:0] glitch_cnt;

    modport master (
        output enable, cfg_filter_len, cfg_edge_sel, glitch_clr,
        input  filt_out, edge_valid, edge_rise, edge_ts, glitch_cnt
    );

    modport slave (
        input  enable, cfg_filter_len, cfg_edge_sel, glitch_clr,
        output filt_out, edge_valid, edge_rise, edge_ts, glitch_cnt
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous pin.
module sync_2ff
    import edge_filter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] stages;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stages <= '0;
        else        stages <= {stages[SYNC_STAGES-2:0], d};
    end

    assign q = stages[SYNC_STAGES-1];
endmodule

// File: rtl/input_edge_filter.sv
// Synchronises the input pin, rejects pulses shorter than cfg_filter_len and
// emits timestamped rising/falling events plus a saturating glitch count.
module input_edge_filter
    import edge_filter_pkg::*;
#(
    parameter int FILTER_WIDTH = 8,
    parameter int GLITCH_WIDTH = 16
) (
    input  logic                s_axi_aclk,
    input  logic                s_axi_aresetn,
    input  logic                input_sig,
    input  logic [63:0]         counter,
    input_edge_filter_if.slave  bus
);
    logic                    sync2;
    logic                    filt_out;
    logic [FILTER_WIDTH-1:0] run_cnt;
    logic [63:0]             cand_ts;
    logic                    edge_valid;
    logic                    edge_rise;
    logic [63:0]             edge_ts;
    logic [GLITCH_WIDTH-1:0] glitch_cnt;

    logic                    mismatch;
    logic                    qualify;
    logic                    glitch;
    logic [FILTER_WIDTH:0]   run_next;

    sync_2ff u_sync (
        .clk   (s_axi_aclk),
        .rst_n (s_axi_aresetn),
        .d     (input_sig),
        .q     (sync2)
    );

    // Extra bit keeps run_cnt + 1 from wrapping when cfg_filter_len is all-ones.
    assign run_next = {1'b0, run_cnt} + 1'b1;
    assign mismatch = (sync2 != filt_out);
    assign qualify  = mismatch && (run_next >= {1'b0, bus.cfg_filter_len});
    assign glitch   = !mismatch && (run_cnt != '0);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            filt_out   <= 1'b0;
            run_cnt    <= '0;
            cand_ts    <= '0;
            edge_valid <= 1'b0;
            edge_rise  <= 1'b0;
            edge_ts    <= '0;
            glitch_cnt <= '0;
        end else begin
            edge_valid <= 1'b0;

            if (bus.glitch_clr)
                glitch_cnt <= '0;
            else if (glitch && (glitch_cnt != '1))
                glitch_cnt <= glitch_cnt + 1'b1;

            if (mismatch) begin
                if (run_cnt == '0)
                    cand_ts <= counter;
                if (qualify) begin
                    filt_out <= sync2;
                    run_cnt  <= '0;
                    // A run of length 0/1 qualifies before cand_ts is loaded, so stamp directly.
                    if (bus.enable && edge_selected(edge_sel_t'(bus.cfg_edge_sel), sync2)) begin
                        edge_valid <= 1'b1;
                        edge_rise  <= sync2;
                        edge_ts    <= (run_cnt == '0) ? counter : cand_ts;
                    end
                end else begin
                    run_cnt <= run_cnt + 1'b1;
                end
            end else begin
                run_cnt <= '0;
            end
        end
    end

    assign bus.filt_out   = filt_out;
    assign bus.edge_valid = edge_valid;
    assign bus.edge_rise  = edge_rise;
    assign bus.edge_ts    = edge_ts;
    assign bus.glitch_cnt = glitch_cnt;
endmodule

// File: tb/tb_input_edge_filter.sv
// Self-checking bench: table-driven edge vectors with an event scoreboard, plus
// hand sequences for glitches, saturation, clear priority, live config and reset.
module tb_input_edge_filter;
    import edge_filter_pkg::*;

    typedef struct {
        logic [7:0] len;
        logic [1:0] sel;
        logic       en;
        logic       pin;
        logic       exp_event;
        logic       exp_filt;
    } vec_t;

    typedef struct {
        logic        rise;
        logic [63:0] ts;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pin = 1'b0;
    logic [63:0] counter = 64'hFEDC_BA98_0000_0000;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];

    input_edge_filter_if #(.FILTER_WIDTH(8), .GLITCH_WIDTH(16)) if_main ();
    input_edge_filter_if #(.FILTER_WIDTH(8), .GLITCH_WIDTH(8))  if_sat ();

    input_edge_filter #(.FILTER_WIDTH(8), .GLITCH_WIDTH(16)) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .input_sig     (pin),
        .counter       (counter),
        .bus           (if_main)
    );

    input_edge_filter #(.FILTER_WIDTH(8), .GLITCH_WIDTH(8)) dut_sat (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .input_sig     (pin),
        .counter       (counter),
        .bus           (if_sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        counter <= counter + 64'd1;
        cyc     <= cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_cfg(input logic [7:0] len, input logic [1:0] sel, input logic en);
        if_main.cfg_filter_len = len;
        if_main.cfg_edge_sel   = sel;
        if_main.enable         = en;
        if_sat.cfg_filter_len  = len;
        if_sat.cfg_edge_sel    = sel;
        if_sat.enable          = en;
    endtask

    task automatic set_clr(input logic v);
        if_main.glitch_clr = v;
        if_sat.glitch_clr  = v;
    endtask

    function automatic int unsigned latency(input logic [7:0] len);
        return ((len == 8'd0) ? 1 : int'(len)) + 2;
    endfunction

    // Expectation for a pin change driven at the current negedge.
    task automatic expect_edge(input logic rise, input logic [7:0] len);
        exp_t e;
        e.rise = rise;
        e.ts   = counter + 64'(TS_LATENCY);
        e.cyc  = cyc + latency(len);
        sb.push_back(e);
    endtask

    // Scoreboard consumer: every event pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && if_main.edge_valid) begin
            if (sb.size() == 0) begin
                check("unexpected edge_valid", {63'd0, if_main.edge_valid}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("event edge_rise", {63'd0, if_main.edge_rise}, {63'd0, e.rise});
                check("event edge_ts", if_main.edge_ts, e.ts);
                check("event cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted, got %0d cycles, expected completion", cyc);
        $fatal(1, "watchdog");
    end

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{8'd4,   BOTH, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[1]  = '{8'd4,   BOTH, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{8'd0,   BOTH, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[3]  = '{8'd1,   BOTH, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{8'd4,   RISE, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[5]  = '{8'd4,   RISE, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{8'd3,   FALL, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{8'd3,   FALL, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{8'd2,   NONE, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{8'd2,   BOTH, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{8'd4,   BOTH, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{8'd4,   BOTH, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{8'd255, BOTH, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[13] = '{8'd255, BOTH, 1'b1, 1'b0, 1'b1, 1'b0};

        set_cfg(8'd4, BOTH, 1'b1);
        set_clr(1'b0);
        repeat (3) @(negedge clk);
        check("reset filt_out", {63'd0, if_main.filt_out}, 64'd0);
        check("reset edge_valid", {63'd0, if_main.edge_valid}, 64'd0);
        check("reset edge_ts", if_main.edge_ts, 64'd0);
        check("reset glitch_cnt", 64'(if_main.glitch_cnt), 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            set_cfg(vecs[i].len, vecs[i].sel, vecs[i].en);
            pin = vecs[i].pin;
            if (vecs[i].exp_event) expect_edge(vecs[i].pin, vecs[i].len);
            repeat (latency(vecs[i].len) + 4) @(negedge clk);
            check($sformatf("vec%0d filt_out", i), {63'd0, if_main.filt_out}, {63'd0, vecs[i].exp_filt});
            check($sformatf("vec%0d pending events", i), 64'(sb.size()), 64'd0);
        end
        check("table glitch_cnt", 64'(if_main.glitch_cnt), 64'd0);

        // Back-to-back opposite edges at minimum spacing L+1.
        set_cfg(8'd2, BOTH, 1'b1);
        pin = 1'b1;
        expect_edge(1'b1, 8'd2);
        repeat (3) @(negedge clk);
        pin = 1'b0;
        expect_edge(1'b0, 8'd2);
        repeat (8) @(negedge clk);
        check("b2b pending events", 64'(sb.size()), 64'd0);
        check("b2b glitch_cnt", 64'(if_main.glitch_cnt), 64'd0);

        // Lowering the filter length mid-run qualifies on the next mismatch cycle.
        set_cfg(8'd10, BOTH, 1'b1);
        pin = 1'b1;
        begin
            exp_t e;
            e.rise = 1'b1;
            e.ts   = counter + 64'(TS_LATENCY);
            e.cyc  = cyc + 5;
            sb.push_back(e);
        end
        repeat (4) @(negedge clk);
        set_cfg(8'd2, BOTH, 1'b1);
        repeat (6) @(negedge clk);
        check("live cfg filt_out", {63'd0, if_main.filt_out}, 64'd1);
        check("live cfg pending events", 64'(sb.size()), 64'd0);
        pin = 1'b0;
        expect_edge(1'b0, 8'd2);
        repeat (8) @(negedge clk);

        // Two-cycle pulse against length 4 is a glitch.
        set_cfg(8'd4, BOTH, 1'b1);
        pin = 1'b1;
        repeat (2) @(negedge clk);
        pin = 1'b0;
        repeat (6) @(negedge clk);
        check("glitch filt_out", {63'd0, if_main.filt_out}, 64'd0);
        check("glitch glitch_cnt", 64'(if_main.glitch_cnt), 64'd1);
        check("glitch sat glitch_cnt", 64'(if_sat.glitch_cnt), 64'd1);

        // 300 single-cycle glitches: 8-bit counter saturates, 16-bit counts on.
        set_cfg(8'd2, BOTH, 1'b1);
        for (int i = 0; i < 300; i++) begin
            pin = 1'b1;
            @(negedge clk);
            pin = 1'b0;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check("sat glitch_cnt 16b", 64'(if_main.glitch_cnt), 64'd301);
        check("sat glitch_cnt 8b", 64'(if_sat.glitch_cnt), 64'hFF);
        check("sat filt_out", {63'd0, if_main.filt_out}, 64'd0);

        // Clear coincident with a glitch increment wins.
        pin = 1'b1;
        @(negedge clk);
        pin = 1'b0;
        repeat (2) @(negedge clk);
        set_clr(1'b1);
        @(negedge clk);
        set_clr(1'b0);
        check("clr glitch_cnt 16b", 64'(if_main.glitch_cnt), 64'd0);
        check("clr glitch_cnt 8b", 64'(if_sat.glitch_cnt), 64'd0);
        repeat (3) @(negedge clk);
        check("clr glitch_cnt settled", 64'(if_main.glitch_cnt), 64'd0);

        // Reset at run_cnt == 2 aborts the run; pin stays high and re-qualifies from scratch.
        set_cfg(8'd4, BOTH, 1'b1);
        pin = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset filt_out", {63'd0, if_main.filt_out}, 64'd0);
        check("midreset edge_valid", {63'd0, if_main.edge_valid}, 64'd0);
        check("midreset edge_rise", {63'd0, if_main.edge_rise}, 64'd0);
        check("midreset edge_ts", if_main.edge_ts, 64'd0);
        check("midreset glitch_cnt", 64'(if_main.glitch_cnt), 64'd0);
        rst_n = 1'b1;
        expect_edge(1'b1, 8'd4);
        repeat (latency(8'd4) + 4) @(negedge clk);
        check("post-reset filt_out", {63'd0, if_main.filt_out}, 64'd1);
        check("post-reset glitch_cnt", 64'(if_main.glitch_cnt), 64'd0);

        repeat (10) @(negedge clk);
        check("final pending events", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/input_edge_filter.md
# input_edge_filter

Front-end conditioning stage for the edge-counter input path. It synchronises the raw asynchronous `input_sig` pin and rejects glitches with a programmable stability filter. It detects qualified rising/falling transitions and stamps each one with the 64-bit TimeController `counter`. Its filtered level and per-edge event pulses feed the edge-counter controller in place of the raw pin.

## Interface
Parameters:
- `FILTER_WIDTH`, 8: width of the filter-length config and run counter.
- `GLITCH_WIDTH`, 16: width of the saturating glitch counter.

Ports:
- `s_axi_aclk`  in  1  single clock for all logic.
- `s_axi_aresetn`  in  1  asynchronous, active-low reset.
- `input_sig`  in  1  raw asynchronous input pin.
- `counter`  in  64  TimeController timestamp, synchronous to `s_axi_aclk`.
- `enable`  in  1  gates event output only; filter keeps tracking when low.
- `cfg_filter_len`  in  FILTER_WIDTH  required consecutive stable cycles; 0 and 1 are equivalent.
- `cfg_edge_sel`  in  2  01 rising, 10 falling, 11 both, 00 none.
- `glitch_clr`  in  1  synchronous clear of `glitch_cnt`.
- `filt_out`  out  1  filtered level.
- `edge_valid`  out  1  one-cycle event pulse.
- `edge_rise`  out  1  direction, valid with `edge_valid` (1 = rising).
- `edge_ts`  out  64  timestamp, valid with `edge_valid`, held until next event.
- `glitch_cnt`  out  GLITCH_WIDTH  saturating count of rejected pulses.

## Operation
- Reset: `sync1`, `sync2`, `filt_out`, `run_cnt`, `cand_ts`, `edge_valid`, `edge_rise`, `edge_ts` and `glitch_cnt` all go to 0.
- Synchroniser: `input_sig` passes through two flops, `sync1` then `sync2`.
- Mismatch cycle (`sync2 != filt_out`):
  - If `run_cnt == 0`, capture `cand_ts <= counter`.
  - If `run_cnt + 1 >= cfg_filter_len` (compared at FILTER_WIDTH+1 bits), then `filt_out <= sync2`, `run_cnt <= 0`, and a qualified transition occurs.
  - Otherwise `run_cnt <= run_cnt + 1`.
- Match cycle (`sync2 == filt_out`):
  - If `run_cnt != 0`, a glitch is detected: `glitch_cnt` increments, saturating at all-ones.
  - `run_cnt <= 0`.
- Qualified transition:
  - If `enable` is high and the direction is selected by `cfg_edge_sel`, register `edge_valid = 1`, `edge_rise = sync2`, and `edge_ts = cand_ts`.
  - When `run_cnt == 0` (length 0/1), `edge_ts` takes the current `counter` value directly.
- `edge_valid` deasserts the cycle after any pulse; there is no handshake and the consumer must accept every pulse.
- `cfg_filter_len` is compared live:
  - Lowering it below `run_cnt + 1` mid-run qualifies on the next mismatch cycle.
  - Raising it extends the run in progress.
- `glitch_clr` has priority over a simultaneous increment; the counter reads 0 the next cycle.
- Deasserting `enable` mid-run does not reset the filter. A qualification with `enable` low updates `filt_out` but emits no event, so no spurious edge appears when `enable` re-asserts.
- The pin is high at reset release and `filt_out` starts at 0. This yields one rising event after the filter delay when enabled, and this is intended.

## Timing
- Let E0 be the clock edge that first samples the new pin level into `sync1`, and L = max(`cfg_filter_len`, 1).
- `sync2` changes at E1.
- `filt_out` changes at edge E(L+1), and `edge_valid` is high in the same cycle (L+2 edges after E0).
- `edge_ts` equals `counter` in the cycle following E1; downstream subtracts a constant 2 to reference E0.
- Minimum event spacing is L+1 cycles; back-to-back opposite edges are each reported.
- An asynchronous reset mid-run aborts the run with no event and no glitch count.

## Structure
- Package `edge_filter_pkg`:
  - enum `edge_sel_t` (NONE, RISE, FALL, BOTH);
  - constant `SYNC_STAGES = 2`;
  - constant `TS_LATENCY = 2`.
- Sub-module `sync_2ff`: a two-flop synchroniser with async active-low reset, reused for other pin inputs.
- The remaining filter, edge and timestamp logic is a single flat always_ff block.

## Test plan
- Filter length 4, both edges, enable=1, pin 0→1 held, `counter` free-running: `edge_valid` pulses once, 6 edges after E0, with `edge_rise=1`, `edge_ts = counter@(E1 cycle)`, and `glitch_cnt=0`.
- Filter length 4, pin high for 2 cycles then low: no event, `filt_out` stays 0, `glitch_cnt=1`.
- Repeat the glitch 0x1_0000 times with `GLITCH_WIDTH=16`: `glitch_cnt` saturates at 0xFFFF. Assert `glitch_clr` in the same cycle as a glitch: `glitch_cnt` reads 0.
- Edge select RISE, pin 0→1→0 with long holds: one event for the rise only, while `filt_out` follows both transitions.
- Enable=0 during a rise, then enable=1: no event, `filt_out=1`; the later fall produces an event with `edge_rise=0`.
- Mid-run reset: pin rises, `s_axi_aresetn` pulses low at `run_cnt=2`, and the pin is held high afterwards. After reset release, all outputs are 0 and a fresh rising event occurs at the full L+2 latency.
